// File: rtl/pipe_trace_pkg.sv
// Shared types for the pipeline trace buffer: capture FSM state encoding
// and the layout of one trace entry (pc is the most significant field).
package pipe_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_t;

  // Field width of the default build; the RAM word is {pc,rs1,rs2,res}
  // in this same order at whatever XLEN the top is built with.
  localparam int TRACE_XLEN = 64;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [TRACE_XLEN-1:0] rs1;
    logic [TRACE_XLEN-1:0] rs2;
    logic [TRACE_XLEN-1:0] res;
  } trace_entry_t;

endpackage

// File: rtl/pipe_trace_buf_ram.sv
// Trace storage: DEPTH words, one synchronous write port and one
// asynchronous read port so the oldest entry is visible the same cycle.
module trace_ram #(
  parameter int W     = 256,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write the captured entry; contents are never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_trace_buf.sv
// Pipeline trace buffer: records {pc,rs1,rs2,res} of a pipeline stage into
// a circular buffer once armed, stops a programmable number of entries after
// a trigger PC, then drains oldest-first over a valid/ready port.
// Optional build macro PIPE_TRACE_FILTER_EN adds a PC range filter
// (flt_lo_i..flt_hi_i inclusive) that gates which entries are stored.
module pipe_trace_buf
  import pipe_trace_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vld_i,
  input  logic [XLEN-1:0]            pc_i,
  input  logic [XLEN-1:0]            rs1_i,
  input  logic [XLEN-1:0]            rs2_i,
  input  logic [XLEN-1:0]            res_i,
  input  logic                       arm_i,
  input  logic [XLEN-1:0]            trig_pc_i,
  input  logic [$clog2(DEPTH):0]     post_cnt_i,
`ifdef PIPE_TRACE_FILTER_EN
  input  logic [XLEN-1:0]            flt_lo_i,
  input  logic [XLEN-1:0]            flt_hi_i,
`endif
  input  logic                       rd_rdy_i,
  output logic                       rd_vld_o,
  output logic [XLEN-1:0]            rd_pc_o,
  output logic [XLEN-1:0]            rd_rs1_o,
  output logic [XLEN-1:0]            rd_rs2_o,
  output logic [XLEN-1:0]            rd_res_o,
  output logic [1:0]                 state_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       trig_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int W  = 4 * XLEN;

  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] MAXPOST = CW'(DEPTH - 1);

  trace_state_t    state, state_nx;
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   count, remaining, post_load;
  logic            trig_q;
  logic            in_range, capturing, store, hit, full, rd_fire;
  logic [W-1:0]    rdata;

`ifdef PIPE_TRACE_FILTER_EN
  assign in_range = (pc_i >= flt_lo_i) && (pc_i <= flt_hi_i);
`else
  assign in_range = 1'b1;
`endif

  assign capturing = (state == ST_ARMED) || (state == ST_POST);
  assign store     = vld_i && capturing && in_range;
  assign hit       = store && (state == ST_ARMED) && (pc_i == trig_pc_i);
  assign full      = (count == FULL_C);
  assign post_load = (post_cnt_i > MAXPOST) ? MAXPOST : post_cnt_i;
  assign rd_vld_o  = (state == ST_DONE) && (count != '0);
  assign rd_fire   = rd_vld_o && rd_rdy_i;

  // Capture FSM next state; arm and reset are applied in the register.
  always_comb begin
    state_nx = state;
    case (state)
      ST_ARMED: if (hit) state_nx = (post_load == '0) ? ST_DONE : ST_POST;
      ST_POST:  if (store && (remaining == ONE_C)) state_nx = ST_DONE;
      default:  state_nx = state;
    endcase
  end

  // FSM state register; arm restarts capture from any state.
  always_ff @(posedge clk) begin
    if (!reset)     state <= ST_IDLE;
    else if (arm_i) state <= ST_ARMED;
    else            state <= state_nx;
  end

  // Pointers, occupancy, post-trigger countdown and trigger pulse.
  always_ff @(posedge clk) begin
    if (!reset || arm_i) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      remaining <= '0;
      trig_q    <= 1'b0;
    end else begin
      trig_q <= hit;
      if (store) begin
        wptr <= wptr + ONE_A;
        // Full buffer: the write lands on the oldest slot, so skip it.
        if (full) rptr  <= rptr + ONE_A;
        else      count <= count + ONE_C;
      end else if (rd_fire) begin
        rptr  <= rptr + ONE_A;
        count <= count - ONE_C;
      end
      if (hit)                              remaining <= post_load;
      else if (store && state == ST_POST)   remaining <= remaining - ONE_C;
    end
  end

  trace_ram #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (store && reset && !arm_i),
    .waddr (wptr),
    .wdata ({pc_i, rs1_i, rs2_i, res_i}),
    .raddr (rptr),
    .rdata (rdata)
  );

  assign rd_pc_o  = rdata[4*XLEN-1 -: XLEN];
  assign rd_rs1_o = rdata[3*XLEN-1 -: XLEN];
  assign rd_rs2_o = rdata[2*XLEN-1 -: XLEN];
  assign rd_res_o = rdata[XLEN-1   -: XLEN];
  assign state_o  = state;
  assign count_o  = count;
  assign trig_o   = trig_q;

endmodule
